mem_dump_ctrl: RTL and testbench

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

---
 rtl/mem_dump_pkg.sv | 30 +++
 rtl/mem_dump_ser.sv | 32 +++
 rtl/mem_dump_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_dump_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// mem_dump shared types: FSM state encoding and word geometry.
// MEM_DUMP_CHECKSUM_EN adds the checksum states.
package mem_dump_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W = 2;

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_FETCH     = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_TX   = 3'd4,
    S_CSUM      = 3'd5,
    S_CSUM_WAIT = 3'd6,
    S_FIN       = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_FETCH   = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_TX = 3'd4,
    S_FIN     = 3'd7
  } state_t;
`endif

endpackage

// File: rtl/mem_dump_ser.sv
// Word register and little-endian byte selector for the dump path.
module mem_dump_ser
  import mem_dump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        next,
  input  logic [31:0] rdata,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0]      word;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= rdata;
      idx  <= '0;
    end else if (next) begin
      idx  <= idx + IDX_W'(1);
    end
  end

  assign byte_out = word[{idx, 3'b000} +: 8];
  assign last = (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_dump_ctrl.sv
// Dumps a ROM range byte-wise to a UART transmitter.
// MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module mem_dump_ctrl
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        tx_byte,
  output logic              tx_send,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] remain;
  logic             abort_pend;
  logic             abort_any;
  logic             accept;
  logic             load;
  logic             next;
  logic             last;
  logic             word_end;
  logic [7:0]       ser_byte;

  assign abort_any = abort | abort_pend;
  assign accept = (state == S_IDLE) && start
                  && (word_count != '0);
  assign load = (state == S_FETCH);
  assign next = (state == S_WAIT_TX) && tx_done
                && !abort_any && !last;
  assign word_end = (state == S_WAIT_TX) && tx_done
                    && !abort_any && last
                    && (remain > CNT_W'(1));
  assign busy = (state != S_IDLE) && (state != S_FIN);

  mem_dump_ser u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .next     (next),
    .rdata    (mem_rdata),
    .byte_out (ser_byte),
    .last     (last)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (start)
          nxt = (word_count == '0) ? S_FIN : S_ADDR;
      S_ADDR:  nxt = abort_any ? S_FIN : S_FETCH;
      S_FETCH: nxt = abort_any ? S_FIN : S_SEND;
      S_SEND:  nxt = abort_any ? S_FIN : S_WAIT_TX;
      S_WAIT_TX:
        if (tx_done) begin
          if (abort_any)
            nxt = S_FIN;
          else if (!last)
            nxt = S_SEND;
          else if (remain > CNT_W'(1))
            nxt = S_ADDR;
          else
`ifdef MEM_DUMP_CHECKSUM_EN
            nxt = S_CSUM;
`else
            nxt = S_FIN;
`endif
        end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM: nxt = abort_any ? S_FIN : S_CSUM_WAIT;
      S_CSUM_WAIT:
        if (tx_done)
          nxt = S_FIN;
`endif
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      remain     <= '0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (state == S_FIN);
      if (accept) begin
        mem_addr <= base_addr;
        remain   <= word_count;
      end else if (word_end) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        remain   <= remain - CNT_W'(1);
      end
      // abort is sticky so a short pulse still ends the dump
      if (state == S_IDLE || state == S_FIN)
        abort_pend <= 1'b0;
      else if (abort)
        abort_pend <= 1'b1;
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_sel;

  assign tx_send = ((state == S_SEND) || (state == S_CSUM))
                   && !abort_any;
  assign tx_byte = csum_sel ? csum : ser_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum     <= '0;
      csum_sel <= 1'b0;
    end else if (accept) begin
      csum     <= '0;
      csum_sel <= 1'b0;
    end else begin
      if (state == S_SEND && tx_send)
        csum <= csum ^ ser_byte;
      if (state == S_WAIT_TX && nxt == S_CSUM)
        csum_sel <= 1'b1;
    end
  end
`else
  assign tx_send = (state == S_SEND) && !abort_any;
  assign tx_byte = ser_byte;
`endif

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Randomized bench for mem_dump_ctrl with a byte-stream reference model.
// Honours MEM_DUMP_CHECKSUM_EN in the expected stream.
module tb_mem_dump_ctrl;

  localparam int AW = 13;
  localparam int CW = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic [7:0]    tx_byte;
  logic          tx_send;
  logic          tx_done = 1'b0;
  logic          busy;
  logic          done;

  mem_dump_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tx_byte    (tx_byte),
    .tx_send    (tx_send),
    .tx_done    (tx_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] rom [DEPTH];
  logic [7:0]  got [$];
  int          send_cyc [$];
  int          txd_cyc [$];
  int          dly_min = 10;
  int          dly_max = 10;
  bit          spurious = 0;
  int          abort_at = 0;
  int          sends = 0;
  int          pend = 0;
  int          abort_st = 0;
  logic [7:0]  held = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // synchronous ROM: one cycle read latency
  initial forever begin
    @(posedge clk);
    mem_rdata <= rom[mem_addr];
  end

  // UART model: records launched bytes, answers with tx_done
  initial forever begin
    @(negedge clk);
    tx_done = 1'b0;
    if (abort_st == 1) begin
      abort = 1'b1;
      abort_st = 2;
    end else if (abort_st == 2) begin
      abort = 1'b0;
      abort_st = 0;
    end
    if (!rst_n) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        tx_done = 1'b1;
        txd_cyc.push_back(cyc);
        chk("hold", tx_byte, held);
      end
    end else if (spurious && $urandom_range(0, 3) == 0) begin
      tx_done = 1'b1;
    end
    if (rst_n && tx_send === 1'b1) begin
      got.push_back(tx_byte);
      send_cyc.push_back(cyc);
      held = tx_byte;
      pend = $urandom_range(dly_min, dly_max);
      sends++;
      if (sends == abort_at)
        abort_st = 1;
    end
  end

  task automatic run(input logic [AW-1:0] b, input int c,
                     input int ak, input string nm);
    logic [7:0]    exp [$];
    logic [7:0]    cs;
    logic [31:0]   w;
    logic [AW-1:0] a;
    int            k;
    int            dc;
    int            bc;
    int            budget;
    int            n;
    int            g;
    cs = '0;
    for (int i = 0; i < c; i++) begin
      a = b + AW'(i);
      w = rom[a];
      for (int j = 0; j < 4; j++) begin
        exp.push_back(w[8*j +: 8]);
        cs = cs ^ w[8*j +: 8];
      end
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    if (c != 0)
      exp.push_back(cs);
`endif
    if (ak > 0)
      while (exp.size() > ak)
        void'(exp.pop_back());
    got.delete();
    send_cyc.delete();
    txd_cyc.delete();
    sends = 0;
    abort_at = ak;
    @(negedge clk);
    base_addr = b;
    word_count = CW'(c);
    start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    if (c != 0) begin
      chk({nm, ".addr0"}, mem_addr, b);
      chk({nm, ".busy"}, busy, 1);
    end
    dc = -1;
    bc = 0;
    budget = 60 + c * 64;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
    chk({nm, ".done_seen"}, dc >= 0, 1);
    if (dc >= 0) begin
      chk({nm, ".busy_at_done"}, busy, 0);
      @(negedge clk);
      chk({nm, ".done_pulse"}, done, 0);
    end
    if (c == 0) begin
      chk({nm, ".done_lat"}, dc - k, 2);
      chk({nm, ".busy_short"}, bc <= 1, 1);
    end
    chk({nm, ".nbytes"}, got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.byte%0d", nm, i), got[i], exp[i]);
    if (send_cyc.size() > 0)
      chk({nm, ".lat0"}, send_cyc[0] - k, 3);
    for (int i = 1; i < send_cyc.size(); i++) begin
      if (i - 1 < txd_cyc.size()) begin
        g = (i % 4 == 0 && i < 4 * c) ? 3 : 1;
        chk($sformatf("%s.gap%0d", nm, i),
            send_cyc[i] - txd_cyc[i-1], g);
      end
    end
    abort_at = 0;
  endtask

  initial begin
    int c;
    int ak;
    bit any_done;
    for (int i = 0; i < DEPTH; i++)
      rom[i] = $urandom;
    rom[0] = 32'h44332211;

    #1;
    chk("reset.outs",
        {mem_addr, tx_byte, tx_send, busy, done}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(13'h0000, 1, 0, "basic");
    run(13'h0000, 0, 0, "empty");
    run(13'h1FFF, 2, 0, "wrap");
    run(13'h0000, 3, 2, "abort");

    // reset during the second word's WAIT_TX
    sends = 0;
    @(negedge clk);
    base_addr = 13'd5;
    word_count = 14'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && sends < 5; i++)
      @(negedge clk);
    chk("rst.reached", sends >= 5, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst.async",
           {mem_addr, tx_byte, tx_send, busy, done}, '0);
    any_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) any_done = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) any_done = 1;
    end
    chk("rst.no_done", any_done, 0);
    run(13'd5, 3, 0, "post_rst");

    dly_min = 1;
    dly_max = 8;
    spurious = 1;
    for (int t = 0; t < 24; t++) begin
      c = $urandom_range(0, 4);
      ak = 0;
      if (c > 0 && $urandom_range(0, 2) == 0)
        ak = $urandom_range(1, 4 * c);
      run(AW'($urandom), c, ak, $sformatf("rnd%0d", t));
    end
    spurious = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
